// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-slot TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS     = 4;
  localparam int SLOT_W        = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: load-to-1 on (re)sync, increment per accepted beat.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  output logic [SLOT_W-1:0] sel,
  output logic              last_slot
);

  logic [SLOT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load1) begin
      cnt_reg <= SLOT_W'(1);
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign sel       = cnt_reg;
  assign last_slot = (cnt_reg == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with frame-sync lock and frame publish strobe.
// Optional even-parity frame drop is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic                   frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                   in_par,
`endif
  output logic [4*WIDTH-1:0]     out,
  output logic [SLOT_W-1:0]      sel,
  output logic                   locked,
  output logic                   frame_valid,
  output logic                   sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic                   par_err
`endif
);

  state_t state_reg, state_next;

  logic last_slot;
  logic sync_beat, acquire, resync, run_beat, frame_end;
  logic ctr_load, wr_en, publish;
  logic [SLOT_W-1:0]          wr_slot;
  logic [NUM_SLOTS-2:0]       shadow_we;
  logic [4*WIDTH-1:0]         frame_data;
  // Slot 3 never needs storage: it goes straight from in to out.
  logic [WIDTH-1:0]           shadow_reg [NUM_SLOTS-1];

  assign sync_beat = in_valid & frame_sync;
  assign acquire   = (state_reg == IDLE) & sync_beat;
  assign resync    = (state_reg == RUN) & sync_beat & (sel != '0);
  assign run_beat  = (state_reg == RUN) & in_valid & ~resync;
  assign frame_end = run_beat & last_slot;
  assign ctr_load  = acquire | resync;
  assign wr_en     = ctr_load | run_beat;
  assign wr_slot   = ctr_load ? '0 : sel;

  tdm_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_beat),
    .load1     (ctr_load),
    .sel       (sel),
    .last_slot (last_slot)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state (only reset leaves RUN)
  always_comb begin
    state_next = state_reg;
    if (acquire) begin
      state_next = RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    locked = (state_reg == RUN);
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS - 1; gi++) begin : g_slot
      assign shadow_we[gi] = wr_en & (wr_slot == SLOT_W'(gi));
      assign frame_data[gi*WIDTH +: WIDTH] = shadow_reg[gi];
    end
  endgenerate
  assign frame_data[(NUM_SLOTS-1)*WIDTH +: WIDTH] = in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        shadow_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (shadow_we[i]) begin
          shadow_reg[i] <= in;
        end
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic beat_perr, perr_flag_reg, frame_bad;

  assign beat_perr = ^{in, in_par};
  assign frame_bad = perr_flag_reg | beat_perr;
  assign publish   = frame_end & ~frame_bad;

  // Sticky per-frame parity flag; a (re)sync beat starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_flag_reg <= 1'b0;
      par_err       <= 1'b0;
    end else begin
      par_err <= frame_end & frame_bad;
      if (ctr_load) begin
        perr_flag_reg <= beat_perr;
      end else if (frame_end) begin
        perr_flag_reg <= 1'b0;
      end else if (run_beat & beat_perr) begin
        perr_flag_reg <= 1'b1;
      end
    end
  end
`else
  assign publish = frame_end;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= publish;
      sync_err    <= resync;
      if (publish) begin
        out <= frame_data;
      end
    end
  end

endmodule
